// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared types and constants for the FFT pipeline stages.
//   VIRTUAL_DATA_WIDTH : default width of one real/imag component (signed)
//   SQRT2_HALF         : round(2^15 * sqrt(2)/2), twiddle constant for butterflies
//   complex_t          : packed {re, im} sample at the default width
//   feeder_state_e     : half-block phase of the butterfly pair feeder
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int VIRTUAL_DATA_WIDTH = 18;
    localparam int SQRT2_HALF         = 23170;

    typedef struct packed {
        logic signed [VIRTUAL_DATA_WIDTH-1:0] re;
        logic signed [VIRTUAL_DATA_WIDTH-1:0] im;
    } complex_t;

    // FILL: first half of a block is being stored.
    // PAIR: second half is arriving and is matched against the stored half.
    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } feeder_state_e;

    function automatic feeder_state_e other_phase(input feeder_state_e s);
        return (s == FILL) ? PAIR : FILL;
    endfunction

endpackage

// File: rtl/feeder_delay_mem.sv
// -----------------------------------------------------------------------------
// feeder_delay_mem
// Half-block delay storage for the butterfly pair feeder: DEPTH entries of
// elem_t, one synchronous write port and one combinational read port. The
// array has no reset; its contents are meaningless until written.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module feeder_delay_mem #(
    parameter int  DEPTH  = 4,
    parameter int  AW     = 2,
    parameter type elem_t = fft_pkg::complex_t
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  elem_t         wdata,
    input  logic [AW-1:0] raddr,
    output elem_t         rdata
);

    elem_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/butterfly_pair_feeder.sv
// -----------------------------------------------------------------------------
// butterfly_pair_feeder
// Front end of one radix-2 FFT stage. Samples arrive serially; the first
// PAIR_DISTANCE samples of every 2*PAIR_DISTANCE block are stored, and each
// sample of the second half is emitted together with its stored partner as a
// registered pair (x[n], x[n+PAIR_DISTANCE]). Data passes bit-exact.
//
// Optional build macro FFT_FEEDER_FRAME_MARK_EN adds out_first, high with the
// first pair of every block.
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   sync                     : restart block alignment (stored half discarded,
//                              pending output pair kept)
//   in_valid/in_ready        : input sample handshake
//   in_real/in_imag          : input sample
//   out_valid/out_ready      : output pair handshake
//   real_out0/imag_out0      : stored sample x[n]
//   real_out1/imag_out1      : partner sample x[n+PAIR_DISTANCE]
//   bfly_enable              : out_valid & out_ready, butterfly input strobe
//   out_first (macro only)   : pair belongs to block index 0
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holding valid keeps its data stable until the transfer;
// ready may depend combinationally on the other side's ready (in_ready in PAIR
// looks at out_ready), never on the same side's valid.
//
// The FSM phase is held in state_q (feeder_state_e) and idx_q for observation.
// -----------------------------------------------------------------------------
module butterfly_pair_feeder #(
    parameter int VIRTUAL_DATA_WIDTH = 18,
    parameter int PAIR_DISTANCE      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sync,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [VIRTUAL_DATA_WIDTH-1:0] in_real,
    input  logic [VIRTUAL_DATA_WIDTH-1:0] in_imag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [VIRTUAL_DATA_WIDTH-1:0] real_out0,
    output logic [VIRTUAL_DATA_WIDTH-1:0] imag_out0,
    output logic [VIRTUAL_DATA_WIDTH-1:0] real_out1,
    output logic [VIRTUAL_DATA_WIDTH-1:0] imag_out1,
    output logic                          bfly_enable
`ifdef FFT_FEEDER_FRAME_MARK_EN
    ,
    output logic                          out_first
`endif
);

    import fft_pkg::*;

    localparam int IDX_W = (PAIR_DISTANCE > 1) ? $clog2(PAIR_DISTANCE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAIR_DISTANCE - 1);

    // Same layout as complex_t, but at this instance's component width.
    typedef struct packed {
        logic signed [VIRTUAL_DATA_WIDTH-1:0] re;
        logic signed [VIRTUAL_DATA_WIDTH-1:0] im;
    } sample_t;

    feeder_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             accept;
    logic             pair_load;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    sample_t          in_sample;
    sample_t          mem_rdata;

    sample_t          out0_q, out1_q;
    logic             out_valid_q;

    assign in_sample = {in_real, in_imag};

    // -------------------------------------------------------------------------
    // Phase / index state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next phase, acceptance and memory control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        in_ready  = 1'b1;
        accept    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        pair_load = 1'b0;

        // In PAIR every accepted sample produces a pair, so the output
        // register must be empty or emptying this cycle.
        if (state_q == PAIR) begin
            in_ready = ~out_valid_q | out_ready;
        end

        accept = in_valid & in_ready;

        if (sync) begin
            // New block starts here: a sample arriving alongside sync is x[0]
            // of that block, never a partner of the discarded half.
            state_d = FILL;
            idx_d   = '0;
            if (accept) begin
                mem_we    = 1'b1;
                mem_waddr = '0;
                if (PAIR_DISTANCE == 1) begin
                    state_d = PAIR;
                end else begin
                    idx_d = IDX_W'(1);
                end
            end
        end else if (accept) begin
            if (state_q == FILL) begin
                mem_we = 1'b1;
            end else begin
                pair_load = 1'b1;
            end
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                state_d = other_phase(state_q);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Half-block storage
    // -------------------------------------------------------------------------
    feeder_delay_mem #(
        .DEPTH  (PAIR_DISTANCE),
        .AW     (IDX_W),
        .elem_t (sample_t)
    ) u_delay_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (in_sample),
        .raddr (idx_q),
        .rdata (mem_rdata)
    );

    // -------------------------------------------------------------------------
    // Output pair register. Loads only on a PAIR acceptance, so it holds
    // while stalled and is untouched by sync or FILL traffic.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
        end else if (pair_load) begin
            out_valid_q <= 1'b1;
            out0_q      <= mem_rdata;
            out1_q      <= in_sample;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef FFT_FEEDER_FRAME_MARK_EN
    logic out_first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_first_q <= 1'b0;
        end else if (pair_load) begin
            out_first_q <= (idx_q == '0);
        end
    end

    assign out_first = out_first_q;
`endif

    assign out_valid   = out_valid_q;
    assign real_out0   = out0_q.re;
    assign imag_out0   = out0_q.im;
    assign real_out1   = out1_q.re;
    assign imag_out1   = out1_q.im;
    assign bfly_enable = out_valid_q & out_ready;

endmodule

// File: tb/tb_butterfly_pair_feeder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_butterfly_pair_feeder
// Directed bench: instance a (PAIR_DISTANCE=4) covers streaming, backpressure,
// sync and asynchronous reset; instance b (PAIR_DISTANCE=1) covers alternating
// phases with random gaps against an expected-pair queue.
// -----------------------------------------------------------------------------
module tb_butterfly_pair_feeder;

    localparam int W  = 18;
    localparam int PW = 4 * W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- instance a (PAIR_DISTANCE = 4) ----------------
    logic         a_sync, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_bfly;
    logic [W-1:0] a_in_real, a_in_imag, a_r0, a_i0, a_r1, a_i1;

    // ---------------- instance b (PAIR_DISTANCE = 1) ----------------
    logic         b_sync, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_bfly;
    logic [W-1:0] b_in_real, b_in_imag, b_r0, b_i0, b_r1, b_i1;

`ifdef FFT_FEEDER_FRAME_MARK_EN
    logic a_first, b_first;
`endif

    butterfly_pair_feeder #(.VIRTUAL_DATA_WIDTH(W), .PAIR_DISTANCE(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .sync(a_sync),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_real(a_in_real), .in_imag(a_in_imag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .real_out0(a_r0), .imag_out0(a_i0), .real_out1(a_r1), .imag_out1(a_i1),
        .bfly_enable(a_bfly)
`ifdef FFT_FEEDER_FRAME_MARK_EN
        , .out_first(a_first)
`endif
    );

    butterfly_pair_feeder #(.VIRTUAL_DATA_WIDTH(W), .PAIR_DISTANCE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .sync(b_sync),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_real(b_in_real), .in_imag(b_in_imag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .real_out0(b_r0), .imag_out0(b_i0), .real_out1(b_r1), .imag_out1(b_i1),
        .bfly_enable(b_bfly)
`ifdef FFT_FEEDER_FRAME_MARK_EN
        , .out_first(b_first)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [PW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] re_of(input int k);
        return W'(k);
    endfunction

    function automatic logic [W-1:0] im_of(input int k);
        return W'(-k);
    endfunction

    function automatic logic [PW-1:0] pair_k(input int k0, input int k1);
        return {re_of(k0), im_of(k0), re_of(k1), im_of(k1)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                           input logic rdy, input logic s);
        a_in_valid  = v;
        a_in_real   = re;
        a_in_imag   = im;
        a_out_ready = rdy;
        a_sync      = s;
    endtask

    task automatic check_a(input string tag, input logic ev, input logic [PW-1:0] ep, input logic ef);
        check({tag, "_valid"}, PW'(a_out_valid), PW'(ev));
        if (ev) check({tag, "_data"}, {a_r0, a_i0, a_r1, a_i1}, ep);
`ifdef FFT_FEEDER_FRAME_MARK_EN
        check({tag, "_first"}, PW'(a_first), PW'(ef));
`else
        if (ef) check({tag, "_first_implies_valid"}, PW'(a_out_valid), PW'(1'b1));
`endif
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int sent, got, cycles;
        logic acc, hs;
        logic [W-1:0] sv_re [4];
        logic [W-1:0] sv_im [4];

        rst_n = 1'b0;
        a_drive(1'b0, '0, '0, 1'b0, 1'b0);
        b_sync = 1'b0; b_in_valid = 1'b0; b_in_real = '0; b_in_imag = '0; b_out_ready = 1'b0;
        #12;

        // Reset state
        check("rst_a_valid", PW'(a_out_valid), '0);
        check("rst_a_data", {a_r0, a_i0, a_r1, a_i1}, '0);
        check("rst_a_in_ready", PW'(a_in_ready), PW'(1'b1));
        check("rst_b_valid", PW'(b_out_valid), '0);
        check("rst_b_data", {b_r0, b_i0, b_r1, b_i1}, '0);
`ifdef FFT_FEEDER_FRAME_MARK_EN
        check("rst_a_first", PW'(a_first), '0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- Test 1: continuous stream k = 0..15 ----
        for (int k = 0; k < 16; k++) begin
            a_drive(1'b1, re_of(k), im_of(k), 1'b1, 1'b0);
            tick();
            check_a($sformatf("t1_k%0d", k), (k % 8) >= 4, pair_k(k - 4, k), (k % 8) == 4);
            check($sformatf("t1_bfly_k%0d", k), PW'(a_bfly), PW'((k % 8) >= 4));
        end
        a_drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check_a("t1_drain", 1'b0, '0, 1'b0);

        // ---- Test 2: backpressure on pair (1,5) ----
        for (int k = 0; k < 6; k++) begin
            a_drive(1'b1, re_of(k), im_of(k), 1'b1, 1'b0);
            tick();
        end
        check_a("t2_p15", 1'b1, pair_k(1, 5), 1'b0);
        for (int c = 0; c < 3; c++) begin
            a_drive(1'b1, re_of(6), im_of(6), 1'b0, 1'b0);
            #1;
            check($sformatf("t2_in_ready_bp%0d", c), PW'(a_in_ready), '0);
            tick();
            check_a($sformatf("t2_hold%0d", c), 1'b1, pair_k(1, 5), 1'b0);
        end
        a_drive(1'b1, re_of(6), im_of(6), 1'b1, 1'b0);
        #1;
        check("t2_in_ready_release", PW'(a_in_ready), PW'(1'b1));
        tick();
        check_a("t2_p26", 1'b1, pair_k(2, 6), 1'b0);
        a_drive(1'b1, re_of(7), im_of(7), 1'b1, 1'b0);
        tick();
        check_a("t2_p37", 1'b1, pair_k(3, 7), 1'b0);
        a_drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check_a("t2_drain", 1'b0, '0, 1'b0);

        // ---- Test 3: sync with the third sample of a new block ----
        for (int k = 0; k < 8; k++) begin
            a_drive(1'b1, W'(18'h100 + k), W'(18'h101 + k), 1'b1, 1'b0);
            tick();
        end
        check_a("t3_pend", 1'b1, {18'h103, 18'h104, 18'h107, 18'h108}, 1'b0);
        a_drive(1'b1, 18'h200, 18'h201, 1'b0, 1'b0);
        tick();
        check_a("t3_hold0", 1'b1, {18'h103, 18'h104, 18'h107, 18'h108}, 1'b0);
        a_drive(1'b1, 18'h201, 18'h202, 1'b0, 1'b0);
        tick();
        a_drive(1'b1, 18'h1FFFF, 18'h20000, 1'b0, 1'b1);
        #1;
        check("t3_sync_in_ready", PW'(a_in_ready), PW'(1'b1));
        tick();
        check_a("t3_hold_sync", 1'b1, {18'h103, 18'h104, 18'h107, 18'h108}, 1'b0);
        for (int k = 1; k < 4; k++) begin
            a_drive(1'b1, W'(18'h300 + k), W'(18'h301 + k), 1'b0, 1'b0);
            #1;
            check($sformatf("t3_fill_ready%0d", k), PW'(a_in_ready), PW'(1'b1));
            tick();
            check_a($sformatf("t3_hold_t%0d", k), 1'b1, {18'h103, 18'h104, 18'h107, 18'h108}, 1'b0);
        end
        a_drive(1'b1, 18'h304, 18'h305, 1'b1, 1'b0);
        #1;
        check("t3_bfly_pending", PW'(a_bfly), PW'(1'b1));
        tick();
        check_a("t3_sync_pair", 1'b1, {18'h1FFFF, 18'h20000, 18'h304, 18'h305}, 1'b1);

        // ---- Test 4: asynchronous reset mid-PAIR with out_valid=1 ----
        a_drive(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("t4_async_rst", 1'b0, '0, 1'b0);
        check("t4_rst_data", {a_r0, a_i0, a_r1, a_i1}, '0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            a_drive(1'b1, re_of(32 + k), im_of(32 + k), 1'b1, 1'b0);
            tick();
            check_a($sformatf("t4_fill%0d", k), 1'b0, '0, 1'b0);
        end
        a_drive(1'b1, re_of(36), im_of(36), 1'b1, 1'b0);
        tick();
        check_a("t4_first_pair", 1'b1, pair_k(32, 36), 1'b1);
        a_drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check_a("t4_drain", 1'b0, '0, 1'b0);

        // ---- Test 5: PAIR_DISTANCE=1 with random gaps ----
        sv_re[0] = 18'h0000A; sv_im[0] = 18'h3FFF6;
        sv_re[1] = 18'h1FFFF; sv_im[1] = 18'h20000;
        sv_re[2] = 18'h12345; sv_im[2] = 18'h00001;
        sv_re[3] = 18'h2ABCD; sv_im[3] = 18'h15432;
        exp_q.push_back({sv_re[0], sv_im[0], sv_re[1], sv_im[1]});
        exp_q.push_back({sv_re[2], sv_im[2], sv_re[3], sv_im[3]});
        sent = 0; got = 0; cycles = 0;
        while ((sent < 4 || got < 2 || cycles < 8) && cycles < 300) begin
            b_in_valid  = (sent < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_in_real   = (sent < 4) ? sv_re[sent] : '0;
            b_in_imag   = (sent < 4) ? sv_im[sent] : '0;
            b_out_ready = (sent < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            acc = b_in_valid & b_in_ready;
            hs  = b_bfly;
            if (hs) begin
                got++;
                if (exp_q.size() == 0) begin
                    check("t5_extra_pulse", PW'(got), PW'(2));
                end else begin
                    check($sformatf("t5_pair%0d", got), {b_r0, b_i0, b_r1, b_i1}, exp_q.pop_front());
                end
`ifdef FFT_FEEDER_FRAME_MARK_EN
                check("t5_first", PW'(b_first), PW'(1'b1));
`endif
            end
            tick();
            if (acc) sent++;
            cycles++;
        end
        check("t5_samples_sent", PW'(sent), PW'(4));
        check("t5_handshakes", PW'(got), PW'(2));
        check("t5_queue_empty", PW'(exp_q.size()), '0);
        check("t5_idle_valid", PW'(b_out_valid), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/butterfly_pair_feeder.md
Name: butterfly_pair_feeder

Overview:
- Upstream stage of the radix-2 butterfly in each FFT pipeline stage.
- Accepts a serial stream of complex samples and buffers the first half of every 2*PAIR_DISTANCE-sample block.
- Emits registered pairs (x[n], x[n+PAIR_DISTANCE]) with a valid/ready handshake, plus an enable strobe for the butterfly's real_in0/imag_in0/real_in1/imag_in1 inputs.

Parameters:
- VIRTUAL_DATA_WIDTH, 18, width of each real/imag component (signed).
- PAIR_DISTANCE, 4, sample distance between butterfly partners. Power of 2, ≥1.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- sync, input, 1, restart block alignment; discard any stored half-block.
- in_valid, input, 1, input sample valid.
- in_ready, output, 1, input sample accepted when in_valid & in_ready.
- in_real, input, VIRTUAL_DATA_WIDTH, signed real part.
- in_imag, input, VIRTUAL_DATA_WIDTH, signed imaginary part.
- out_valid, output, 1, pair valid.
- out_ready, input, 1, consumer accepts pair.
- real_out0, output, VIRTUAL_DATA_WIDTH, stored sample x[n] real part.
- imag_out0, output, VIRTUAL_DATA_WIDTH, stored sample x[n] imaginary part.
- real_out1, output, VIRTUAL_DATA_WIDTH, partner sample x[n+PAIR_DISTANCE] real part.
- imag_out1, output, VIRTUAL_DATA_WIDTH, partner sample x[n+PAIR_DISTANCE] imaginary part.
- bfly_enable, output, 1, combinational out_valid & out_ready.

Behaviour:
- Reset (asynchronous, rst_n=0): state=FILL, idx=0, out_valid=0, all data outputs 0. Delay memory contents are don't-care.
- States and index:
  - FILL: accepted sample is written to mem[idx].
  - PAIR: accepted sample is paired with mem[idx].
  - idx has width max(1, log2(PAIR_DISTANCE)) and increments on each accepted sample.
  - When idx wraps from PAIR_DISTANCE-1 to 0, state toggles FILL↔PAIR.
- in_ready:
  - FILL: constant 1.
  - PAIR: ~out_valid | out_ready (output register free or being drained this cycle).
- PAIR acceptance:
  - Next cycle: out_valid=1, real_out0/imag_out0 = mem[idx], real_out1/imag_out1 = input sample.
  - Latency is one cycle from acceptance to out_valid.
- Output stability: while out_valid & ~out_ready, all outputs hold stable.
- out_valid clears after a handshake unless a new PAIR sample is accepted in the same cycle. Back-to-back pairs sustain 1 pair/cycle.
- No arithmetic and no width change. Data passes bit-exact.
- FILL-phase handshake: an output pair may complete (out_ready) while FILL samples are accepted. The two are independent.
- sync=1:
  - Next state is FILL with idx=0. Partially stored data is discarded.
  - A pending output pair is NOT dropped. out_valid and data are kept until handshake.
  - A sample accepted in the same cycle as sync is stored as mem[0] of the new block, and idx becomes 1.
- PAIR_DISTANCE=1: FILL and PAIR alternate every accepted sample.
- Reset mid-block: all stored data is lost and the first post-reset sample is treated as x[0].
- in_valid=0 cycles in either state: no state change.

Optional Feature:
- Macro: FFT_FEEDER_FRAME_MARK_EN.
- Defined: adds output out_first (1 bit).
  - out_first=1 with the pair whose idx was 0 (first pair of each block). It holds with the data under backpressure.
  - Reset value 0.
- Undefined: port absent; no extra logic.

Decomposition:
- Shared package fft_pkg:
  - complex_t packed struct {logic signed [VIRTUAL_DATA_WIDTH-1:0] re, im}.
  - feeder_state_e enum {FILL, PAIR}.
  - Default VIRTUAL_DATA_WIDTH.
  - SQRT2_HALF=23170 constant, shared with the butterflies.
- Sub-module feeder_delay_mem:
  - PAIR_DISTANCE x complex_t register array.
  - One write port (we, waddr, wdata) and one combinational read port.
  - No reset on the array.

Test Plan:
- Continuous stream, PAIR_DISTANCE=4, out_ready=1, samples k=(re=k, im=-k) for k=0..15 → pairs (0,4),(1,5),(2,6),(3,7),(8,12)…(11,15). Each pair appears one cycle after its second sample; out_valid is low during samples 8..11.
- Backpressure: out_ready=0 for 3 cycles while the pair (1,5) is valid → outputs stable and in_ready=0. Sample 6 is accepted on the cycle out_ready returns to 1, and pair (2,6) follows next cycle.
- sync asserted with sample 2 of a block (value 0x1FFFF) → that sample becomes x[0] of the new block. The pair already pending completes unchanged, and the next pair is (0x1FFFF, fourth sample after sync).
- Reset asserted mid-PAIR with out_valid=1 → out_valid and data outputs are 0 immediately (asynchronous). After release, the first 4 samples produce no output.
- PAIR_DISTANCE=1, random in_valid gaps, samples a,b,c,d → pairs (a,b),(c,d). bfly_enable pulses exactly once per handshake.
- With FFT_FEEDER_FRAME_MARK_EN, PAIR_DISTANCE=4, 16 samples → out_first=1 only on pairs (0,4) and (8,12).
